// File: rtl/fft_frame_rx.sv
// FFT output frame receiver: bin counting, two-stage power peak search.
// Optional aborted-frame counter: define FFT_FRAME_RX_ERRCNT_EN.
module fft_frame_rx #(
  parameter int N = 256,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in_n,
  input  logic                   sop_in_n,
  input  logic signed [W-1:0]    y_re,
  input  logic signed [W-1:0]    y_im,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [$clog2(N)-1:0]   peak_bin,
  output logic [2*W:0]           peak_pwr,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int BW = $clog2(N);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;

  logic acc, sop;
  logic take, first, last, abort;

  logic signed [2*W-1:0] re_x, im_x;
  logic signed [2*W-1:0] sq_re, sq_im;
  logic [2*W:0] pwr;

  logic          s1_vld, s1_first, s1_last, s1_err;
  logic [2*W:0]  s1_pwr;
  logic [BW-1:0] s1_bin;

  logic [2*W:0]  run_pwr;
  logic [BW-1:0] run_bin;
  logic          beat;

  assign acc  = ~valid_in_n;
  assign sop  = acc & ~sop_in_n;
  assign busy = (state_q == RECV);

  // Squares of W-bit signed values fit in 2W signed bits; the sum needs 2W+1.
  assign re_x  = (2*W)'(y_re);
  assign im_x  = (2*W)'(y_im);
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;
  assign pwr   = {1'b0, sq_re} + {1'b0, sq_im};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    abort   = 1'b0;
    unique case (1'b1)
      sop: begin
        state_d = RECV;
        cnt_d   = BW'(1);
        take    = 1'b1;
        first   = 1'b1;
        abort   = (state_q == RECV);
      end
      (acc && sop_in_n && state_q == RECV): begin
        take = 1'b1;
        if (cnt_q == BW'(N-1)) begin
          last    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_err   <= 1'b0;
      s1_pwr   <= '0;
      s1_bin   <= '0;
    end else begin
      s1_vld   <= take;
      s1_first <= first;
      s1_last  <= last;
      s1_err   <= abort;
      if (take) begin
        s1_pwr <= pwr;
        s1_bin <= first ? '0 : cnt_q;
      end
    end
  end

  // Strictly greater: ties keep the earlier (lower) bin.
  assign beat = (s1_pwr > run_pwr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_pwr    <= '0;
      run_bin    <= '0;
      peak_pwr   <= '0;
      peak_bin   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= s1_vld & s1_last;
      frame_err  <= s1_vld & s1_err;
      if (s1_vld) begin
        if (s1_first || beat) begin
          run_pwr <= s1_pwr;
          run_bin <= s1_bin;
        end
        if (s1_last) begin
          peak_pwr <= beat ? s1_pwr : run_pwr;
          peak_bin <= beat ? s1_bin : run_bin;
        end
      end
    end
  end

`ifdef FFT_FRAME_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (frame_err && err_cnt != 8'hff) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_frame_rx.sv
// Directed bench for fft_frame_rx: peak search, gaps, abort, ties,
// back-to-back frames and mid-frame reset.
module tb_fft_frame_rx;

  logic               clk;
  logic               rst;
  logic               valid_in_n;
  logic               sop_in_n;
  logic signed [15:0] y_re;
  logic signed [15:0] y_im;
  logic               frame_done;
  logic               frame_err;
  logic [7:0]         peak_bin;
  logic [32:0]        peak_pwr;
  logic               busy;
  logic [7:0]         err_cnt;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int last_acc = 0;
  int start_acc = 0;

  int done_n = 0;
  int err_n = 0;
  int both_n = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  int last_done_bin = 0;
  int prev_done_bin = 0;
  int err_cyc = 0;

  fft_frame_rx #(.N(256), .W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in_n (valid_in_n),
    .sop_in_n   (sop_in_n),
    .y_re       (y_re),
    .y_im       (y_im),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .peak_bin   (peak_bin),
    .peak_pwr   (peak_pwr),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) begin
      done_n        <= done_n + 1;
      prev_done_cyc <= last_done_cyc;
      prev_done_bin <= last_done_bin;
      last_done_cyc <= cyc;
      last_done_bin <= int'(peak_bin);
    end
    if (frame_err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (frame_done && frame_err) both_n <= both_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in_n = 1'b1;
      sop_in_n   = 1'b1;
    end
  endtask

  task automatic drive(input logic signed [15:0] re,
                       input logic signed [15:0] im,
                       input logic sop);
    @(negedge clk);
    valid_in_n = 1'b0;
    sop_in_n   = ~sop;
    y_re       = re;
    y_im       = im;
    last_acc   = cyc + 1;
  endtask

  task automatic send_frame(input int nb, input int pb,
                            input logic signed [15:0] pre,
                            input logic signed [15:0] pim,
                            input logic signed [15:0] bre,
                            input logic signed [15:0] bim,
                            input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (i == pb) drive(pre, pim, i == 0);
      else         drive(bre, bim, i == 0);
      if (i == 0) start_acc = last_acc;
      if (i == 1) check("busy_recv", busy, 1);
      if (gaps && (i % 10 == 9) && (i != nb - 1)) idle(3);
    end
  endtask

  task automatic end_frame(input int exp_n, input int eb,
                           input logic [32:0] ep);
    idle(2);
    #1;
    check("done_pulse", frame_done, 1);
    check("done_cnt", done_n, exp_n);
    check("done_lat", last_done_cyc - last_acc, 1);
    check("peak_bin", peak_bin, eb);
    check("peak_pwr", peak_pwr, ep);
    check("busy_idle", busy, 0);
    idle(1);
    #1;
    check("done_clr", frame_done, 0);
    check("peak_hold", peak_bin, eb);
  endtask

  initial begin
    int base_done;
    int base_err;
    rst        = 1'b1;
    valid_in_n = 1'b1;
    sop_in_n   = 1'b1;
    y_re       = '0;
    y_im       = '0;

    idle(3);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_bin", peak_bin, 0);
    check("rst_pwr", peak_pwr, 0);
    check("rst_busy", busy, 0);
    check("rst_errcnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // bin 37 dominates
    send_frame(256, 37, 16'sd1000, -16'sd1000, 16'sd1, 16'sd1, 1'b0);
    end_frame(1, 37, 33'd2000000);

    // same frame with 3-cycle gaps every 10 bins
    send_frame(256, 37, 16'sd1000, -16'sd1000, 16'sd1, 16'sd1, 1'b1);
    end_frame(2, 37, 33'd2000000);

    // early sop at bin 100, then a full frame peaking at bin 5
    base_err = err_n;
    send_frame(100, -1, 16'sd0, 16'sd0, 16'sd1, 16'sd1, 1'b0);
    send_frame(256, 5, 16'sd300, 16'sd400, 16'sd1, 16'sd1, 1'b0);
    end_frame(3, 5, 33'd250000);
    check("err_pulses", err_n - base_err, 1);
    check("err_lat", err_cyc - start_acc, 1);
`ifdef FFT_FRAME_RX_ERRCNT_EN
    check("err_cnt", err_cnt, 1);
`else
    check("err_cnt", err_cnt, 0);
`endif

    // all bins at full negative scale: tie keeps bin 0, no overflow
    send_frame(256, -1, 16'sd0, 16'sd0, -16'sd32768, -16'sd32768, 1'b0);
    end_frame(4, 0, 33'd2147483648);

    // two back-to-back frames
    send_frame(256, 10, 16'sd50, 16'sd0, 16'sd1, 16'sd1, 1'b0);
    send_frame(256, 200, 16'sd40, 16'sd0, 16'sd1, 16'sd1, 1'b0);
    end_frame(6, 200, 33'd1600);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 256);
    check("b2b_bin1", prev_done_bin, 10);

    // reset in the middle of a frame
    base_done = done_n;
    base_err  = err_n;
    send_frame(128, -1, 16'sd0, 16'sd0, 16'sd7, 16'sd7, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    valid_in_n = 1'b1;
    sop_in_n   = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pwr", peak_pwr, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(16'sd9, 16'sd9, 1'b0);
    idle(3);
    #1;
    check("post_rst_done", done_n - base_done, 0);
    check("post_rst_err", err_n - base_err, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_bin", peak_bin, 0);
    check("post_rst_pwr", peak_pwr, 0);
    check("post_rst_errcnt", err_cnt, 0);
    check("done_err_excl", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_rx.md
FFT_FRAME_RX -- requirements
Module: fft_frame_rx

Interface
REQ-001 SHALL have parameter N, default 256, meaning FFT frame length in bins (power of 2).
REQ-002 SHALL have parameter W, default 16, meaning signed sample width per component.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port valid_in_n, input, 1, meaning sample valid, active low; connects to FFT valid_out.
REQ-006 SHALL have port sop_in_n, input, 1, meaning start of frame (bin 0), active low, qualified by valid_in_n=0.
REQ-007 SHALL have port y_re, input, W, meaning signed real part.
REQ-008 SHALL have port y_im, input, W, meaning signed imaginary part.
REQ-009 SHALL have port frame_done, output, 1, meaning one-cycle pulse when a complete frame is received.
REQ-010 SHALL have port frame_err, output, 1, meaning one-cycle pulse when a frame is aborted by an early sop.
REQ-011 SHALL have port peak_bin, output, log2(N), meaning index of the max-power bin of the last good frame.
REQ-012 SHALL have port peak_pwr, output, 2W+1, meaning unsigned re^2+im^2 of that bin.
REQ-013 SHALL have port busy, output, 1, meaning state is RECV.
REQ-014 SHALL have port err_cnt, output, 8, meaning saturating aborted-frame count (see Configuration).

Function
REQ-015 SHALL accept a sample on each rising edge where valid_in_n=0; valid_in_n=1 cycles are gaps and SHALL leave all counters unchanged.
REQ-016 SHALL implement states IDLE and RECV; IDLE discards accepted samples with sop_in_n=1.
REQ-017 SHALL, on an accepted sample with sop_in_n=0 in any state, treat it as bin 0: bin counter=1, running peak = that sample, running peak index=0, state RECV.
REQ-018 SHALL compute power as re*re+im*im, exact in 2W+1 bits unsigned; -2^(W-1) in both parts SHALL give 2^(2W-1) without overflow.
REQ-019 SHALL register power and bin index in a stage-1 register at the accepting edge; stage 2 SHALL compare on the next edge.
REQ-020 SHALL update the running peak only if the new power is strictly greater; ties keep the lower bin index.
REQ-021 SHALL, when bin N-1 is accepted at edge k, load peak_bin/peak_pwr and pulse frame_done=1 for one cycle starting at edge k+1, and return to IDLE at edge k.
REQ-022 SHALL hold peak_bin/peak_pwr unchanged between frame_done pulses.
REQ-023 SHALL, on an accepted sop in RECV with bin counter in 1..N-1, pulse frame_err at edge k+1, discard partial results, and restart per REQ-017 with that sample as bin 0.
REQ-024 SHALL, if sop arrives with bin N-1 not yet accepted but following a completed frame in IDLE, raise no error.
REQ-025 SHALL never assert frame_done and frame_err in the same cycle.
REQ-026 SHALL tolerate back-to-back frames with zero gap: bin 0 of frame f+1 accepted on the edge after bin N-1 of frame f.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, counters 0, stage registers 0, frame_done=0, frame_err=0, peak_bin=0, peak_pwr=0, busy=0, err_cnt=0.
REQ-028 SHALL, on reset mid-frame, discard the partial frame with no frame_done or frame_err after release.

Configuration
REQ-029 SHALL, when macro FFT_FRAME_RX_ERRCNT_EN is defined, increment err_cnt by 1 on each frame_err pulse, saturating at 255, cleared only by rst.
REQ-030 SHALL, when FFT_FRAME_RX_ERRCNT_EN is undefined, tie err_cnt to 0 and synthesize no counter logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: 256-bin frame, bin 37 = (re=1000, im=-1000), others (1,1) -> frame_done one cycle after bin 255, peak_bin=37, peak_pwr=2000000.
REQ-032 SHALL cover: same frame with valid_in_n=1 gaps of 3 cycles every 10 bins -> identical results, frame_done one cycle after last accepted bin.
REQ-033 SHALL cover: sop at bin 100, then full 256-bin frame with peak at bin 5 -> frame_err pulse, err_cnt=1 (macro defined) or 0 (undefined), then frame_done with peak_bin=5.
REQ-034 SHALL cover: all bins (-32768,-32768) -> peak_bin=0, peak_pwr=2147483648 (tie rule, no overflow).
REQ-035 SHALL cover: two zero-gap frames with peaks at bins 10 and 200 -> two frame_done pulses 256 cycles apart, peak_bin 10 then 200.
REQ-036 SHALL cover: rst=1 at bin 128, released, then samples without sop -> no pulses, busy=0, outputs 0.
